// File: rtl/rob_nway.sv
// rtl/rob_nway.sv - N-way reorder buffer with branch-mask kill, CDB completion and in-order commit
//
// Purpose: circular reorder buffer. Dispatch enqueues up to DISP_W entries per
// cycle, completion ports mark entries done (optionally excepted), and up to
// COMMIT_W in-order head entries retire per cycle. Branch resolution either
// clears a mask bit (clean) or kills every entry tagged with it (mispredict).
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   disp_valid/data/mask  dispatch lanes (contiguous from lane 0)
//   disp_ready          at least DISP_W free entries
//   disp_index          pointer assigned to each dispatch lane
//   cdb_valid/index/exc completion ports
//   commit_valid/data/exc  committable head lanes
//   commit_ready        consumer takes every offered lane
//   br_valid/tag/kill/wptr  branch resolution broadcast
//   flush               full pipeline flush
//   count, empty, full  occupancy

module rob_nway #(
  parameter  int DEPTH    = 32,
  parameter  int DISP_W   = 2,
  parameter  int COMMIT_W = 2,
  parameter  int CDB_W    = 2,
  parameter  int NBR      = 4,
  parameter  int DATA_W   = 64,
  localparam int AW       = $clog2(DEPTH),
  localparam int TW       = (NBR > 1) ? $clog2(NBR) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DISP_W-1:0]                disp_valid,
  input  logic [DISP_W-1:0][DATA_W-1:0]    disp_data,
  input  logic [DISP_W-1:0][NBR-1:0]       disp_mask,
  output logic                             disp_ready,
  output logic [DISP_W-1:0][AW:0]          disp_index,
  input  logic [CDB_W-1:0]                 cdb_valid,
  input  logic [CDB_W-1:0][AW-1:0]         cdb_index,
  input  logic [CDB_W-1:0]                 cdb_exc,
  output logic [COMMIT_W-1:0]              commit_valid,
  output logic [COMMIT_W-1:0][DATA_W-1:0]  commit_data,
  output logic [COMMIT_W-1:0]              commit_exc,
  input  logic                             commit_ready,
  input  logic                             br_valid,
  input  logic [TW-1:0]                    br_tag,
  input  logic                             br_kill,
  input  logic [AW:0]                      br_wptr,
  input  logic                             flush,
  output logic [AW:0]                      count,
  output logic                             empty,
  output logic                             full
);

  localparam int PW = AW + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]             wptr;
  logic [PW-1:0]             rptr;
  logic [DEPTH-1:0]          busy;
  logic [DEPTH-1:0]          done;
  logic [DEPTH-1:0]          exc;
  logic [DEPTH-1:0][NBR-1:0] mask;
  logic [DATA_W-1:0]         data [DEPTH];

  logic                      kill;
  logic                      clean;
  logic                      disp_we;
  logic                      commit_fire;
  logic [NBR-1:0]            tag_onehot;
  logic [PW-1:0]             disp_num;
  logic [PW-1:0]             commit_num;
  logic [DISP_W-1:0][AW-1:0] disp_slot;
  logic [DISP_W-1:0][NBR-1:0] lane_mask;
  logic [COMMIT_W-1:0][AW-1:0] commit_slot;
  logic [DEPTH-1:0]          kill_hit;
  logic [DEPTH-1:0]          cdb_set;
  logic [DEPTH-1:0]          cdb_exc_set;

  // ---------------------------------------------------------------------------
  // Occupancy and dispatch side
  // ---------------------------------------------------------------------------
  assign count       = wptr - rptr;
  assign empty       = (count == '0);
  assign full        = (count == PW'(DEPTH));
  assign disp_ready  = ((PW'(DEPTH) - count) >= PW'(DISP_W));

  assign kill        = br_valid & br_kill;
  assign clean       = br_valid & ~br_kill;
  assign tag_onehot  = NBR'(1) << br_tag;
  // A kill rewinds wptr, so whatever is dispatched alongside it is younger
  // than the branch and must be dropped.
  assign disp_we     = disp_ready & ~kill & ~flush;
  assign commit_fire = commit_ready & ~flush;

  always_comb begin
    disp_num   = '0;
    disp_index = '0;
    disp_slot  = '0;
    lane_mask  = '0;
    for (int i = 0; i < DISP_W; i++) begin
      disp_index[i] = wptr + PW'(i);
      disp_slot[i]  = wptr[AW-1:0] + AW'(i);
      // A clean resolution also covers lanes entering this very cycle.
      lane_mask[i]  = disp_mask[i] & ~(clean ? tag_onehot : '0);
      disp_num      = disp_num + PW'(disp_valid[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Completion: per-entry set vectors so two ports hitting one entry OR their
  // exception flags instead of the last write winning.
  // ---------------------------------------------------------------------------
  always_comb begin
    kill_hit    = '0;
    cdb_set     = '0;
    cdb_exc_set = '0;
    for (int e = 0; e < DEPTH; e++) begin
      kill_hit[e] = kill & mask[e][br_tag];
    end
    for (int p = 0; p < CDB_W; p++) begin
      if (cdb_valid[p] && busy[cdb_index[p]] && !kill_hit[cdb_index[p]]) begin
        cdb_set[cdb_index[p]]     = 1'b1;
        cdb_exc_set[cdb_index[p]] = cdb_exc_set[cdb_index[p]] | cdb_exc[p];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Commit: lane j is offered only if every head entry up to j is done and no
  // earlier lane is excepted; an excepted entry itself is still offered so the
  // consumer sees the exception at the head.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic          ok;
    logic          v;
    logic [AW-1:0] cs;
    ok           = 1'b1;
    v            = 1'b0;
    cs           = '0;
    commit_num   = '0;
    commit_slot  = '0;
    commit_valid = '0;
    commit_exc   = '0;
    commit_data  = '0;
    for (int j = 0; j < COMMIT_W; j++) begin
      cs              = rptr[AW-1:0] + AW'(j);
      v               = ok & busy[cs] & done[cs];
      commit_slot[j]  = cs;
      commit_valid[j] = v;
      commit_exc[j]   = v & exc[cs];
      commit_data[j]  = data[cs];
      commit_num      = commit_num + PW'(v);
      ok              = v & ~exc[cs];
    end
  end

  // ---------------------------------------------------------------------------
  // Control state. Later nonblocking writes win, which orders dispatch after
  // completion/clean for the same slot.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      busy <= '0;
      done <= '0;
      exc  <= '0;
      mask <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      busy <= '0;
    end else begin
      // Head entries are older than any resolving branch, so commit also
      // proceeds in a kill cycle.
      if (commit_fire) begin
        for (int j = 0; j < COMMIT_W; j++) begin
          if (commit_valid[j]) busy[commit_slot[j]] <= 1'b0;
        end
        rptr <= rptr + commit_num;
      end

      for (int e = 0; e < DEPTH; e++) begin
        if (cdb_set[e]) begin
          done[e] <= 1'b1;
          exc[e]  <= exc[e] | cdb_exc_set[e];
        end
        if (clean)       mask[e][br_tag] <= 1'b0;
        if (kill_hit[e]) busy[e]         <= 1'b0;
      end

      if (kill) begin
        wptr <= br_wptr;
      end else if (disp_ready) begin
        for (int i = 0; i < DISP_W; i++) begin
          if (disp_valid[i]) begin
            busy[disp_slot[i]] <= 1'b1;
            done[disp_slot[i]] <= 1'b0;
            exc[disp_slot[i]]  <= 1'b0;
            mask[disp_slot[i]] <= lane_mask[i];
          end
        end
        wptr <= wptr + disp_num;
      end
    end
  end

  // Payload needs no reset; it is only observed through busy entries.
  always_ff @(posedge clk) begin
    if (disp_we) begin
      for (int i = 0; i < DISP_W; i++) begin
        if (disp_valid[i]) data[disp_slot[i]] <= disp_data[i];
      end
    end
  end

endmodule

// File: tb/tb_rob_nway.sv
// tb/tb_rob_nway.sv - directed self-checking bench for rob_nway

module tb_rob_nway;

  logic              clk;
  logic              rst;
  logic [1:0]        disp_valid;
  logic [1:0][15:0]  disp_data;
  logic [1:0][3:0]   disp_mask;
  logic              disp_ready;
  logic [1:0][3:0]   disp_index;
  logic [1:0]        cdb_valid;
  logic [1:0][2:0]   cdb_index;
  logic [1:0]        cdb_exc;
  logic [1:0]        commit_valid;
  logic [1:0][15:0]  commit_data;
  logic [1:0]        commit_exc;
  logic              commit_ready;
  logic              br_valid;
  logic [1:0]        br_tag;
  logic              br_kill;
  logic [3:0]        br_wptr;
  logic              flush;
  logic [3:0]        count;
  logic              empty;
  logic              full;

  int n_cmp = 0;
  int n_err = 0;

  rob_nway #(
    .DEPTH(8), .DISP_W(2), .COMMIT_W(2), .CDB_W(2), .NBR(4), .DATA_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_data(disp_data), .disp_mask(disp_mask),
    .disp_ready(disp_ready), .disp_index(disp_index),
    .cdb_valid(cdb_valid), .cdb_index(cdb_index), .cdb_exc(cdb_exc),
    .commit_valid(commit_valid), .commit_data(commit_data), .commit_exc(commit_exc),
    .commit_ready(commit_ready),
    .br_valid(br_valid), .br_tag(br_tag), .br_kill(br_kill), .br_wptr(br_wptr),
    .flush(flush), .count(count), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Protocol: dispatch lanes must be contiguous from lane 0.
  always @(posedge clk) begin
    if (rst) begin
      assert (disp_valid !== 2'b10) else begin
        n_err++;
        $error("FAIL protocol: non-contiguous disp_valid observed=%0b", disp_valid);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    disp_valid   = '0;
    disp_data    = '0;
    disp_mask    = '0;
    cdb_valid    = '0;
    cdb_index    = '0;
    cdb_exc      = '0;
    commit_ready = 1'b0;
    br_valid     = 1'b0;
    br_tag       = '0;
    br_kill      = 1'b0;
    br_wptr      = '0;
    flush        = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp2(input logic [15:0] d0, input logic [15:0] d1, input logic [3:0] m);
    disp_valid   = 2'b11;
    disp_data[0] = d0;
    disp_data[1] = d1;
    disp_mask[0] = m;
    disp_mask[1] = m;
  endtask

  task automatic cdb2(input logic [2:0] i0, input logic [2:0] i1);
    cdb_valid    = 2'b11;
    cdb_index[0] = i0;
    cdb_index[1] = i1;
  endtask

  initial begin
    int wp;
    int base;
    idle();
    rst = 1'b0;

    // Reset state
    #3;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ready", disp_ready, 1);
    chk("rst_cvalid", commit_valid, 0);
    chk("rst_dindex", disp_index, 8'h10);
    tick();
    rst = 1'b1;
    tick();

    // Fill: four cycles of two lanes
    for (int c = 0; c < 4; c++) begin
      disp2(16'h0100 + 16'(2*c), 16'h0101 + 16'(2*c), 4'b0000);
      #1;
      chk("fill_dindex", disp_index, {4'(2*c+1), 4'(2*c)});
      tick();
    end
    idle();
    #1;
    chk("fill_count", count, 8);
    chk("fill_full", full, 1);
    chk("fill_ready", disp_ready, 0);
    chk("fill_empty", empty, 0);
    disp2(16'hdead, 16'hbeef, 4'b0000);
    tick();
    idle();
    #1;
    chk("fill5_count", count, 8);
    chk("fill5_wptr", disp_index, 8'h98);

    // Out-of-order completion
    cdb_valid = 2'b01; cdb_index[0] = 3'd1;
    tick(); idle(); #1;
    chk("ooo_cv_first", commit_valid, 2'b00);
    cdb_valid = 2'b01; cdb_index[0] = 3'd0;
    tick(); idle(); #1;
    chk("ooo_cv_second", commit_valid, 2'b11);
    chk("ooo_cdata", commit_data, 32'h0101_0100);
    chk("ooo_cexc", commit_exc, 2'b00);
    commit_ready = 1'b1;
    tick(); idle(); #1;
    chk("ooo_count", count, 6);
    chk("ooo_cv_after", commit_valid, 2'b00);
    chk("ooo_ready", disp_ready, 1);

    // Flush overrides same-cycle dispatch
    flush = 1'b1;
    disp2(16'h1111, 16'h2222, 4'b0000);
    tick(); idle(); #1;
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_dindex", disp_index, 8'h10);

    // Kill: entries 2..5 carry mask bit 1
    disp2(16'h0200, 16'h0201, 4'b0000); tick();
    disp2(16'h0202, 16'h0203, 4'b0010); tick();
    disp2(16'h0204, 16'h0205, 4'b0010); tick();
    idle(); #1;
    chk("kill_pre_count", count, 6);
    br_valid = 1'b1; br_tag = 2'd1; br_kill = 1'b1; br_wptr = 4'd2;
    disp2(16'h0bad, 16'h0bad, 4'b0000);
    cdb_valid = 2'b01; cdb_index[0] = 3'd3;
    tick(); idle(); #1;
    chk("kill_count", count, 2);
    chk("kill_wptr", disp_index, 8'h32);
    cdb2(3'd0, 3'd1);
    tick(); idle(); #1;
    chk("kill_cv", commit_valid, 2'b11);
    chk("kill_cdata", commit_data, 32'h0201_0200);

    // Commit during a kill; br_wptr equals rptr after commit -> empty
    commit_ready = 1'b1;
    br_valid = 1'b1; br_tag = 2'd2; br_kill = 1'b1; br_wptr = 4'd2;
    tick(); idle(); #1;
    chk("killcommit_count", count, 0);
    chk("killcommit_empty", empty, 1);
    chk("killcommit_cv", commit_valid, 2'b00);

    // Clean resolution clears tag 2 in stored entries and same-cycle lanes
    disp2(16'h0300, 16'h0301, 4'b0100); tick();
    disp2(16'h0302, 16'h0303, 4'b0100);
    br_valid = 1'b1; br_tag = 2'd2; br_kill = 1'b0;
    tick(); idle();
    br_valid = 1'b1; br_tag = 2'd2; br_kill = 1'b1; br_wptr = 4'd6;
    tick(); idle(); #1;
    chk("clean_count", count, 4);
    cdb2(3'd2, 3'd3);
    tick(); idle(); #1;
    chk("clean_cv1", commit_valid, 2'b11);
    chk("clean_cdata1", commit_data, 32'h0301_0300);
    commit_ready = 1'b1;
    cdb2(3'd4, 3'd5);
    tick(); idle(); #1;
    chk("clean_cv2", commit_valid, 2'b11);
    chk("clean_cdata2", commit_data, 32'h0303_0302);
    chk("clean_count2", count, 2);
    commit_ready = 1'b1;
    tick(); idle(); #1;
    chk("clean_drain", count, 0);

    // Wrap: steady two in / two out, 20 cycles
    wp = 6;
    disp2(16'h1000, 16'h1001, 4'b0000);
    tick(); idle();
    cdb2(3'(wp % 8), 3'((wp + 1) % 8));
    tick(); idle();
    wp = wp + 2;
    for (int i = 1; i <= 10; i++) begin
      base = 16'h1000 + 2*i;
      disp2(16'(base), 16'(base + 1), 4'b0000);
      commit_ready = 1'b1;
      #1;
      chk("wrap_cv", commit_valid, 2'b11);
      chk("wrap_cdata", commit_data, {16'(base - 1), 16'(base - 2)});
      tick(); idle(); #1;
      chk("wrap_count_a", count, 2);
      cdb2(3'(wp % 8), 3'((wp + 1) % 8));
      tick(); idle(); #1;
      chk("wrap_count_b", count, 2);
      wp = wp + 2;
    end
    commit_ready = 1'b1;
    #1;
    chk("wrap_last_cdata", commit_data, 32'h1015_1014);
    tick(); idle(); #1;
    chk("wrap_end_count", count, 0);
    chk("wrap_end_dindex", disp_index, {4'((wp + 1) % 16), 4'(wp % 16)});

    // Exception at the head blocks younger lanes
    flush = 1'b1;
    tick(); idle();
    disp2(16'h0400, 16'h0401, 4'b0000);
    tick(); idle();
    cdb2(3'd0, 3'd0); cdb_exc = 2'b10;
    tick(); idle();
    cdb_valid = 2'b01; cdb_index[0] = 3'd1;
    tick(); idle(); #1;
    chk("exc_cv", commit_valid, 2'b01);
    chk("exc_cexc", commit_exc, 2'b01);
    chk("exc_cdata0", commit_data[0], 16'h0400);
    flush = 1'b1;
    tick(); idle(); #1;
    chk("exc_flush_count", count, 0);
    chk("exc_flush_empty", empty, 1);
    chk("exc_flush_cv", commit_valid, 2'b00);

    // Asynchronous reset mid-cycle while full
    for (int c = 0; c < 4; c++) begin
      disp2(16'h0500 + 16'(c), 16'h0600 + 16'(c), 4'b0000);
      tick();
    end
    idle(); #1;
    chk("areset_pre_full", full, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("areset_count", count, 0);
    chk("areset_empty", empty, 1);
    chk("areset_full", full, 0);
    chk("areset_ready", disp_ready, 1);
    chk("areset_cv", commit_valid, 2'b00);
    chk("areset_dindex", disp_index, 8'h10);
    tick();
    rst = 1'b1;
    tick(); #1;
    chk("areset_post_empty", empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rob_nway.md
ROB_NWAY -- requirements
Module: rob_nway

Interface
REQ-001 SHALL have parameter DEPTH, default 32, entry count (power of 2, >=4); AW=log2(DEPTH).
REQ-002 SHALL have parameter DISP_W, default 2, dispatch lanes per cycle.
REQ-003 SHALL have parameter COMMIT_W, default 2, commit lanes per cycle.
REQ-004 SHALL have parameter CDB_W, default 2, completion ports.
REQ-005 SHALL have parameter NBR, default 4, branch-tag count (branch-mask width).
REQ-006 SHALL have parameter DATA_W, default 64, opaque entry payload width.
REQ-007 SHALL have ports, one per line, clock and reset first:
  clk  in  1  single clock; all state on rising edge
  rst  in  1  reset, asynchronous assert, active-low (0 = reset)
  disp_valid  in  DISP_W  lane enqueue request; valid lanes contiguous from lane 0
  disp_data  in  DISP_W x DATA_W  lane payload
  disp_mask  in  DISP_W x NBR  lane branch mask
  disp_ready  out  1  free entries >= DISP_W
  disp_index  out  DISP_W x (AW+1)  pointer assigned to each lane
  cdb_valid  in  CDB_W  completion strobe
  cdb_index  in  CDB_W x AW  completing entry
  cdb_exc  in  CDB_W  completion carries exception
  commit_valid  out  COMMIT_W  lane holds committable entry
  commit_data  out  COMMIT_W x DATA_W  lane payload
  commit_exc  out  COMMIT_W  lane entry excepted
  commit_ready  in  1  consumer accepts all offered lanes
  br_valid  in  1  branch resolution broadcast
  br_tag  in  log2(NBR)  resolving tag
  br_kill  in  1  1 = mispredict kill, 0 = clean
  br_wptr  in  AW+1  pointer one past the resolving branch
  flush  in  1  full pipeline flush
  count  out  AW+1  occupied entries
  empty  out  1  count==0
  full  out  1  count==DEPTH

Function
REQ-008 SHALL keep wptr/rptr of AW+1 bits; slot = low AW bits; extra bit disambiguates full/empty across wrap.
REQ-009 SHALL compute count = wptr - rptr modulo 2^(AW+1); disp_ready, full, empty, count combinational from registered state.
REQ-010 SHALL, when disp_ready, enqueue lanes 0..k-1 (k = valid lanes) at slots wptr..wptr+k-1 with busy=1, done=0, exc=0, and advance wptr by k; zero-latency index: disp_index[i]=wptr+i.
REQ-011 SHALL ignore disp_valid when disp_ready=0 (no state change).
REQ-012 SHALL set done=1 and exc|=cdb_exc for each cdb_valid port whose target entry is busy; same index on two ports legal (exc OR'd); CDB to a non-busy entry ignored.
REQ-013 SHALL assert commit_valid[j] iff entries rptr..rptr+j all busy and done, and no lane <j has exc=1; lane j payload = entry rptr+j.
REQ-014 SHALL, on commit_ready with m lanes valid, clear busy on those m entries and advance rptr by m in the same edge.
REQ-015 SHALL, on br_valid & ~br_kill, clear mask bit br_tag in every entry and in every lane enqueued that cycle.
REQ-016 SHALL, on br_valid & br_kill, clear busy on every entry with mask bit br_tag set, set wptr=br_wptr, and discard all dispatch lanes that cycle.
REQ-017 SHALL let commit proceed in a kill cycle (head entries are older than the branch); br_wptr==rptr after commit yields empty.
REQ-018 SHALL ignore CDB writes in a kill cycle to entries being killed.
REQ-019 SHALL, on flush, clear all busy, set wptr=rptr=0, and discard dispatch, CDB, commit and branch actions that cycle; flush has priority over all.
REQ-020 SHALL prioritise per edge: flush > kill > {commit, CDB, clean, dispatch}.
REQ-021 SHALL treat non-contiguous disp_valid, or CDB to an entry dispatching the same cycle, as protocol violations (behaviour undefined; assertion in bench).

Reset
REQ-022 SHALL on rst=0 asynchronously clear wptr, rptr, all busy/done/exc/mask bits; outputs: count=0, empty=1, full=0, disp_ready=1, commit_valid=0, disp_index lanes = 0..DISP_W-1.
REQ-023 SHALL release reset synchronously to clk; reset mid-operation discards all in-flight entries.

Verification (DEPTH=8, DISP_W=2, COMMIT_W=2, CDB_W=2, NBR=4)
REQ-024 Fill: dispatch 2/cycle for 4 cycles -> count=8, full=1, disp_ready=0; 5th dispatch ignored, wptr=8 ('b1000).
REQ-025 Out-of-order complete: CDB index 1 then 0 -> commit_valid=00 after first, 11 after second; rptr+=2 with commit_ready=1.
REQ-026 Wrap: 20 cycles steady 2-in/2-out -> pointers wrap twice, count stays 2, payload order preserved.
REQ-027 Kill: entries 2..5 mask bit 1, br_valid, tag=1, kill, br_wptr=2 -> wptr=2, entries 2..5 busy=0, same-cycle dispatch dropped, count=2.
REQ-028 Exception: entry 0 done exc=1, entry 1 done -> commit_valid=01, commit_exc=01; then flush -> count=0, empty=1.
REQ-029 Async reset asserted mid-cycle while full -> outputs reach reset values before next clk edge.
